channel_scanner: RTL

Parametrised, registered N-channel 1-bit selector with manual and auto-scan modes. In manual mode it forwards the bit chosen by `sel`, like a plain switch-selected mux. In auto mode it steps through every channel in turn, holding each for a programmable number of enabled cycles. It drives an LED or downstream serialiser from board switches and reports the active channel, a per-change strobe and a wrap pulse.

---
 rtl/channel_scanner.sv | 92 +++++++++
 1 files changed

// File: rtl/channel_scanner.sv
// N-channel 1-bit selector: manual switch-select or timed auto-scan,
// with registered data, active-channel index, change strobe and wrap pulse.
module channel_scanner #(
    parameter int   CHANNELS    = 7,
    parameter int   SEL_W       = 3,
    parameter int   DIV         = 4,
    parameter logic DEFAULT_OUT = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                enable,
    input  logic [SEL_W-1:0]    sel,
    input  logic [CHANNELS-1:0] data_in,
    output logic                out,
    output logic [SEL_W-1:0]    cur_ch,
    output logic                strobe,
    output logic                wrap
);

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int               SPAN     = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic [SEL_W-1:0] ch_next;
    logic             wrap_next;
    logic [SPAN-1:0]  padded;

    // Every selectable index maps to a bit; unused indices read DEFAULT_OUT.
    generate
        for (genvar gi = 0; gi < SPAN; gi++) begin : g_pad
            if (gi < CHANNELS) begin : g_in
                assign padded[gi] = data_in[gi];
            end else begin : g_def
                assign padded[gi] = DEFAULT_OUT;
            end
        end
    endgenerate

    always_comb begin
        // Dwell always restarts from zero on the first scan cycle after manual.
        cnt_base  = (state_reg == SCAN) ? cnt_reg : '0;
        cnt_next  = cnt_base;
        ch_next   = cur_ch;
        wrap_next = 1'b0;
        if (!mode) begin
            ch_next  = sel;
            cnt_next = '0;
        end else if (enable) begin
            if (cnt_base == CNT_LAST) begin
                cnt_next = '0;
                if (cur_ch < CH_LAST) begin
                    ch_next = cur_ch + 1'b1;
                end else begin
                    ch_next   = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                cnt_next = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= MANUAL;
            cnt_reg   <= '0;
            cur_ch    <= '0;
            out       <= 1'b0;
            strobe    <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_reg <= mode ? SCAN : MANUAL;
            cnt_reg   <= cnt_next;
            cur_ch    <= ch_next;
            out       <= padded[ch_next];
            strobe    <= (ch_next != cur_ch);
            wrap      <= wrap_next;
        end
    end

endmodule
